// File: rtl/nibble_add_seq.sv
// Nibble-serial adder: one 4-bit add-with-carry per clock, WIDTH/4 cycles per operation.
// Optional subtract mode is enabled by defining SEQ_ADD_SUB_EN.
module nibble_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             carry_init;
  logic [WIDTH-1:0] a_r, b_r, b_eff;
  logic [3:0]       nib_a, nib_b;
  logic [4:0]       nib_sum;
  logic [WIDTH-1:0] s_nxt;
  logic             last;
  logic             accept;

  function automatic logic [4:0] add_nib(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

`ifdef SEQ_ADD_SUB_EN
  logic sub_r;

  always_ff @(posedge clk) begin
    if (accept) sub_r <= sub;
  end

  // Two's-complement subtract: invert b and seed the carry with 1.
  assign b_eff      = sub_r ? ~b_r : b_r;
  assign carry_init = sub;
`else
  logic unused_sub;

  assign unused_sub = sub;
  assign b_eff      = b_r;
  assign carry_init = 1'b0;
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (idx == IDX_W'(NIB - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Operands are held privately so later input changes cannot disturb the result.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b;
    end
  end

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    s_nxt = s;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_a = a_r[4*i +: 4];
        nib_b = b_eff[4*i +: 4];
      end
    end
    nib_sum = add_nib(nib_a, nib_b, carry);
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) s_nxt[4*i +: 4] = nib_sum[3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The index parks on the last nibble rather than wrapping; the next start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s     <= '0;
            cout  <= 1'b0;
            idx   <= '0;
            carry <= carry_init;
          end
        end
        RUN: begin
          s     <= s_nxt;
          carry <= nib_sum[4];
          if (last) cout <= nib_sum[4];
          else      idx  <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Randomized self-checking bench for nibble_add_seq (WIDTH=16 and WIDTH=8 instances).
module tb_nibble_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub;
  logic [15:0] a, b;
  logic        busy, done, cout;
  logic [15:0] s;

  logic        start8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8;
  logic [7:0]  s8;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  nibble_add_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .s(s), .cout(cout)
  );

  nibble_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8)
  );

  // Reference: {cout, s} from plain unsigned arithmetic.
  function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic op_sub);
    int unsigned ux, uy;
    ux = x;
    uy = y;
`ifdef SEQ_ADD_SUB_EN
    if (op_sub) return {(ux >= uy), 16'((ux - uy) & 32'hFFFF)};
`endif
    return 17'(ux + uy);
  endfunction

  // Runs one operation; reports result, latency (edges after acceptance), busy cycles,
  // and how many RUN cycles showed a partial sum inconsistent with the reference.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tsub,
                       output logic [15:0] rs, output logic rc, output int lat,
                       output int bcnt, output int midbad);
    logic [16:0] exp;
    logic [15:0] mask;
    exp    = model16(ta, tb_v, tsub);
    lat    = -1;
    bcnt   = 0;
    midbad = 0;
    @(negedge clk);
    a = ta; b = tb_v; sub = tsub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) begin
        bcnt++;
        mask = (i >= 4) ? 16'hFFFF : 16'((32'd1 << (4 * i)) - 1);
        if (s !== (exp[15:0] & mask)) midbad++;
      end
      @(posedge clk);
    end
    rs = s;
    rc = cout;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start8 = 1'b0; sub = 1'b0; sub8 = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    #12;
    checks++;
    if ({busy, done, cout, s} !== 19'd0)
      $display("FAIL reset16 busy=%b done=%b cout=%b s=%h required all 0", busy, done, cout, s);
    else passes++;
    checks++;
    if ({busy8, done8, cout8, s8} !== 11'd0)
      $display("FAIL reset8 busy=%b done=%b cout=%b s=%h required all 0", busy8, done8, cout8, s8);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] rs; logic rc; int lat, bcnt, midbad;
    do_op(16'h1234, 16'h4321, 1'b0, rs, rc, lat, bcnt, midbad);
    checks++;
    if ({rc, rs} !== 17'h05555) $display("FAIL basic_result got %b_%h required 0_5555", rc, rs);
    else passes++;
    checks++;
    if (lat !== 4 || bcnt !== 4)
      $display("FAIL basic_timing latency=%0d busy=%0d required 4/4", lat, bcnt);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || s !== 16'h5555)
      $display("FAIL basic_done_pulse done=%b busy=%b s=%h required 0/0/5555", done, busy, s);
    else passes++;
  endtask

  task automatic test_carry_chain();
    logic [15:0] rs; logic rc; int lat, bcnt, midbad;
    do_op(16'hFFFF, 16'h0001, 1'b0, rs, rc, lat, bcnt, midbad);
    checks++;
    if ({rc, rs} !== 17'h10000) $display("FAIL carry_chain got %b_%h required 1_0000", rc, rs);
    else passes++;
    checks++;
    if (midbad !== 0 || lat !== 4)
      $display("FAIL carry_chain_run bad_partials=%0d latency=%0d required 0/4", midbad, lat);
    else passes++;
  endtask

  task automatic test_start_held();
    int  lat;
    logic seen;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'hDEAD; b = 16'hBEEF;
    for (int op = 0; op < 2; op++) begin
      lat = -1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) begin lat = i; break; end
        if (i == 0 && op == 1) begin
          checks++;
          if (busy !== 1'b1 || s !== 16'h0000)
            $display("FAIL held_reaccept busy=%b s=%h required 1/0000", busy, s);
          else passes++;
        end
        @(posedge clk);
      end
      checks++;
      if ({cout, s} !== 17'h01000 || lat !== 4)
        $display("FAIL held_result%0d got %b_%h lat=%0d required 0_1000 lat 4", op, cout, s, lat);
      else passes++;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h1000)
        $display("FAIL held_idle%0d busy=%b done=%b s=%h required 0/0/1000", op, busy, done, s);
      else passes++;
      if (op == 1) start = 1'b0;
      else begin a = 16'h0F0F; b = 16'h00F1; end
      @(posedge clk);
      #1;
      if (op == 0) begin a = 16'h1111; b = 16'h2222; end
    end
    @(negedge clk);
    seen = busy;
    checks++;
    if (seen !== 1'b0) $display("FAIL held_release busy=%b required 0", seen);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] rs; logic rc; int lat, bcnt, midbad;
    logic saw_done;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, s} !== 19'd0)
      $display("FAIL midrun_reset busy=%b done=%b cout=%b s=%h required all 0", busy, done, cout, s);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) $display("FAIL midrun_no_done activity=%b required 0", saw_done);
    else passes++;
    do_op(16'hAAAA, 16'h5555, 1'b0, rs, rc, lat, bcnt, midbad);
    checks++;
    if ({rc, rs} !== 17'h0FFFF) $display("FAIL midrun_rerun got %b_%h required 0_ffff", rc, rs);
    else passes++;
  endtask

  task automatic test_sub_mode();
    logic [15:0] rs; logic rc; int lat, bcnt, midbad;
`ifdef SEQ_ADD_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b1, rs, rc, lat, bcnt, midbad);
    checks++;
    if ({rc, rs} !== 17'h0FFFE) $display("FAIL sub_neg got %b_%h required 0_fffe", rc, rs);
    else passes++;
    do_op(16'h0007, 16'h0005, 1'b1, rs, rc, lat, bcnt, midbad);
    checks++;
    if ({rc, rs} !== 17'h10002) $display("FAIL sub_pos got %b_%h required 1_0002", rc, rs);
    else passes++;
`else
    do_op(16'h0005, 16'h0007, 1'b1, rs, rc, lat, bcnt, midbad);
    checks++;
    if ({rc, rs} !== 17'h0000C) $display("FAIL sub_ignored got %b_%h required 0_000c", rc, rs);
    else passes++;
`endif
  endtask

  task automatic test_random();
    logic [15:0] rs, ta, tb_v; logic rc, ts; int lat, bcnt, midbad;
    logic [16:0] exp;
    for (int n = 0; n < 24; n++) begin
      ta = 16'($urandom);
      tb_v = (n == 0) ? ta : 16'($urandom);
      ts = 1'($urandom);
      exp = model16(ta, tb_v, ts);
      do_op(ta, tb_v, ts, rs, rc, lat, bcnt, midbad);
      checks++;
      if ({rc, rs} !== exp || lat !== 4 || bcnt !== 4 || midbad !== 0)
        $display("FAIL random%0d a=%h b=%h sub=%b got %b_%h lat=%0d busy=%0d bad=%0d required %b_%h 4/4/0",
                 n, ta, tb_v, ts, rc, rs, lat, bcnt, midbad, exp[16], exp[15:0]);
      else passes++;
    end
  endtask

  task automatic test_width8();
    logic [7:0] ta, tb_v;
    logic [8:0] exp;
    int lat, bcnt;
    for (int n = 0; n < 6; n++) begin
      ta   = (n == 0) ? 8'hC8 : 8'($urandom);
      tb_v = (n == 0) ? 8'h64 : 8'($urandom);
      exp  = 9'({1'b0, ta} + {1'b0, tb_v});
      lat = -1; bcnt = 0;
      @(negedge clk);
      a8 = ta; b8 = tb_v; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done8) begin lat = i; break; end
        if (busy8) bcnt++;
        @(posedge clk);
      end
      checks++;
      if ({cout8, s8} !== exp || lat !== 2 || bcnt !== 2)
        $display("FAIL width8_%0d a=%h b=%h got %b_%h lat=%0d busy=%0d required %b_%h 2/2",
                 n, ta, tb_v, cout8, s8, lat, bcnt, exp[8], exp[7:0]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_start_held();
    test_reset_mid_run();
    test_sub_mode();
    test_random();
    test_width8();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
